// File: rtl/i2s_receive_sync.sv
// I2S / left-justified serial audio receiver running in the system clock domain.
// Oversamples sck/ws/sd, assembles left/right slots and presents complete frames on a valid/ready pair.
module i2s_receive_sync #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned MODE  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sck,
   input  logic             ws,
   input  logic             sd,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             locked,
   output logic             overrun,
   input  logic             clr_overrun
);

   localparam int unsigned   CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic             sck_s1_q, sck_s1_d;
   logic             sck_s2_q, sck_s2_d;
   logic             sck_s3_q, sck_s3_d;
   logic             ws_s1_q, ws_s1_d;
   logic             ws_s2_q, ws_s2_d;
   logic             sd_s1_q, sd_s1_d;
   logic             sd_s2_q, sd_s2_d;
   logic             prev_ws_q, prev_ws_d;
   logic             prev_chan_q, prev_chan_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] left_hold_q, left_hold_d;
   logic [WIDTH-1:0] out_left_q, out_left_d;
   logic [WIDTH-1:0] out_right_q, out_right_d;
   logic             out_valid_q, out_valid_d;
   logic             locked_q, locked_d;
   logic             overrun_q, overrun_d;

   logic             bit_evt;
   logic             chan;
   logic             slot_start;
   logic             frame_done;
   logic             drop;
   logic [CW-1:0]    bit_idx;

   always_comb begin
      sck_s1_d    = sck;
      sck_s2_d    = sck_s1_q;
      sck_s3_d    = sck_s2_q;
      ws_s1_d     = ws;
      ws_s2_d     = ws_s1_q;
      sd_s1_d     = sd;
      sd_s2_d     = sd_s1_q;
      prev_ws_d   = prev_ws_q;
      prev_chan_d = prev_chan_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      left_hold_d = left_hold_q;
      out_left_d  = out_left_q;
      out_right_d = out_right_q;
      out_valid_d = out_valid_q;
      locked_d    = locked_q;
      overrun_d   = overrun_q;
      drop        = 1'b0;

      // ws/sd are taken from the same stage as the sck edge so all three agree
      bit_evt    = sck_s2_q & ~sck_s3_q;
      chan       = (MODE == 0) ? prev_ws_q : ws_s2_q;
      slot_start = bit_evt && (chan != prev_chan_q);
      bit_idx    = slot_start ? '0 : bit_cnt_q;
      frame_done = slot_start && prev_chan_q && locked_q;

      if (bit_evt) begin
         prev_ws_d   = ws_s2_q;
         prev_chan_d = chan;
         bit_cnt_d   = (bit_idx < CNT_MAX) ? bit_idx + CNT_ONE : CNT_MAX;
         if (slot_start) begin
            shift_d = '0;
         end
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bit_idx == CW'(i)) begin
               shift_d[WIDTH-1-i] = sd_s2_q;
            end
         end
      end

      // A committed right slot is forwarded straight from the shifter, so the
      // frame is available in the same clk that closes it.
      if (slot_start) begin
         if (!prev_chan_q) begin
            left_hold_d = shift_q;
         end
         if (!chan) begin
            locked_d = 1'b1;
         end
      end

      if (frame_done) begin
         if (!out_valid_q || out_ready) begin
            out_left_d  = left_hold_q;
            out_right_d = shift_q;
            out_valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (clr_overrun) begin
         overrun_d = 1'b0;
      end
      if (drop) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_s1_q    <= 1'b0;
         sck_s2_q    <= 1'b0;
         sck_s3_q    <= 1'b0;
         ws_s1_q     <= 1'b0;
         ws_s2_q     <= 1'b0;
         sd_s1_q     <= 1'b0;
         sd_s2_q     <= 1'b0;
         prev_ws_q   <= 1'b0;
         prev_chan_q <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         left_hold_q <= '0;
         out_left_q  <= '0;
         out_right_q <= '0;
         out_valid_q <= 1'b0;
         locked_q    <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sck_s1_q    <= sck_s1_d;
         sck_s2_q    <= sck_s2_d;
         sck_s3_q    <= sck_s3_d;
         ws_s1_q     <= ws_s1_d;
         ws_s2_q     <= ws_s2_d;
         sd_s1_q     <= sd_s1_d;
         sd_s2_q     <= sd_s2_d;
         prev_ws_q   <= prev_ws_d;
         prev_chan_q <= prev_chan_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         left_hold_q <= left_hold_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
         out_valid_q <= out_valid_d;
         locked_q    <= locked_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_left  = out_left_q;
   assign out_right = out_right_q;
   assign out_valid = out_valid_q;
   assign locked    = locked_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_receive_sync.sv
// Bench for i2s_receive_sync: one MODE 0 and one MODE 1 receiver share the same serial lines;
// per-frame expectations come from a table and are checked through per-receiver queues.
module tb_i2s_receive_sync;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sck = 1'b0;
   logic        ws = 1'b0;
   logic        sd = 1'b0;
   logic        out_ready = 1'b1;
   logic        clr_overrun = 1'b0;
   logic [23:0] out_left0, out_right0, out_left1, out_right1;
   logic        out_valid0, out_valid1, locked0, locked1, overrun0, overrun1;

   int unsigned passed = 0;
   int unsigned total  = 0;

   typedef struct {
      bit          framing;
      int unsigned slot;
      int unsigned dbits;
      logic [23:0] l, r;
      logic [23:0] e0l, e0r, e1l, e1r;
      bit          push;
   } row_t;

   row_t        vec [14];
   logic [47:0] q0 [$];
   logic [47:0] q1 [$];
   bit          chan_q [$];
   bit          data_q [$];

   i2s_receive_sync #(.WIDTH(24), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
      .out_left(out_left0), .out_right(out_right0), .out_valid(out_valid0),
      .out_ready(out_ready), .locked(locked0), .overrun(overrun0),
      .clr_overrun(clr_overrun)
   );

   i2s_receive_sync #(.WIDTH(24), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
      .out_left(out_left1), .out_right(out_right1), .out_valid(out_valid1),
      .out_ready(out_ready), .locked(locked1), .overrun(overrun1),
      .clr_overrun(clr_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid0 && out_ready) begin
         if (q0.size() == 0) begin
            total++;
            $display("FAIL dut0_unexpected_frame actual=%h_%h required=none", out_left0, out_right0);
         end else begin
            logic [47:0] e;
            e = q0.pop_front();
            check("dut0_left", {8'h0, out_left0}, {8'h0, e[47:24]});
            check("dut0_right", {8'h0, out_right0}, {8'h0, e[23:0]});
         end
      end
      if (rst_n && out_valid1 && out_ready) begin
         if (q1.size() == 0) begin
            total++;
            $display("FAIL dut1_unexpected_frame actual=%h_%h required=none", out_left1, out_right1);
         end else begin
            logic [47:0] e;
            e = q1.pop_front();
            check("dut1_left", {8'h0, out_left1}, {8'h0, e[47:24]});
            check("dut1_right", {8'h0, out_right1}, {8'h0, e[23:0]});
         end
      end
   end

   task automatic add_slot(input bit ch, input int unsigned slot, input int unsigned dbits,
                           input logic [23:0] v);
      for (int unsigned j = 0; j < slot; j++) begin
         chan_q.push_back(ch);
         data_q.push_back((j < dbits) ? v[dbits-1-j] : 1'b0);
      end
   endtask

   task automatic build_rows(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         if (vec[i].push) begin
            q0.push_back({vec[i].e0l, vec[i].e0r});
            q1.push_back({vec[i].e1l, vec[i].e1r});
         end
         add_slot(1'b0, vec[i].slot, vec[i].dbits, vec[i].l);
         add_slot(1'b1, vec[i].slot, vec[i].dbits, vec[i].r);
      end
   endtask

   // Philips framing moves ws one bit ahead of the slot it announces.
   task automatic send_stream(input bit framing, input int rel_idx, input int chk_idx);
      #($urandom_range(0, 9));
      for (int k = 0; k < chan_q.size(); k++) begin
         if (k == rel_idx) rst_n = 1'b1;
         if (k == chk_idx) begin
            check("locked0_before_left_start", 32'(locked0), 32'd0);
            check("locked1_before_left_start", 32'(locked1), 32'd0);
         end
         ws  = (framing == 1'b0 && k + 1 < chan_q.size()) ? chan_q[k+1] : chan_q[k];
         sd  = data_q[k];
         #20 sck = 1'b1;
         #20 sck = 1'b0;
      end
      chan_q.delete();
      data_q.delete();
   endtask

   task automatic do_reset(input bit hold);
      rst_n = 1'b0;
      #1;
      check("rst_out_valid0", 32'(out_valid0), 32'd0);
      check("rst_locked0", 32'(locked0), 32'd0);
      check("rst_locked1", 32'(locked1), 32'd0);
      check("rst_overrun0", 32'(overrun0), 32'd0);
      check("rst_out_left0", {8'h0, out_left0}, 32'd0);
      check("rst_out_right1", {8'h0, out_right1}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      if (!hold) rst_n = 1'b1;
   endtask

   task automatic drain;
      for (int i = 0; i < 400; i++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         @(posedge clk);
      end
      repeat (4) @(posedge clk);
      check("dut0_pending_frames", q0.size(), 32'd0);
      check("dut1_pending_frames", q1.size(), 32'd0);
      check("locked0_after_frames", 32'(locked0), 32'd1);
      check("locked1_after_frames", 32'(locked1), 32'd1);
   endtask

   task automatic run_segment(input int first, input int last, input bit framing);
      add_slot(1'b1, 8, 0, 24'h0);
      build_rows(first, last);
      add_slot(1'b0, 4, 0, 24'h0);
      send_stream(framing, -1, -1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          framing slot dbits l         r          e0l        e0r        e1l        e1r        push
      vec[0]  = '{1'b0, 32, 24, 24'hABCDEF, 24'h123456, 24'hABCDEF, 24'h123456, 24'h55E6F7, 24'h091A2B, 1'b1};
      vec[1]  = '{1'b0, 32, 24, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000001, 24'h7FFFFF, 24'h000000, 1'b1};
      vec[2]  = '{1'b0, 32, 24, 24'h800000, 24'hC00001, 24'h800000, 24'hC00001, 24'h400000, 24'h600000, 1'b1};
      vec[3]  = '{1'b0, 16, 16, 24'h00BEEF, 24'h001234, 24'hBEEF00, 24'h123400, 24'h5F7700, 24'h891A00, 1'b1};
      vec[4]  = '{1'b0, 16, 16, 24'h000001, 24'h008000, 24'h000100, 24'h800000, 24'h000000, 24'hC00000, 1'b1};
      vec[5]  = '{1'b1, 32, 24, 24'hABCDEF, 24'h123456, 24'h579BDE, 24'h2468AC, 24'hABCDEF, 24'h123456, 1'b1};
      vec[6]  = '{1'b1, 32, 24, 24'h7FFFFF, 24'h800001, 24'hFFFFFE, 24'h000002, 24'h7FFFFF, 24'h800001, 1'b1};
      vec[7]  = '{1'b0, 32, 24, 24'h111111, 24'h222222, 24'h111111, 24'h222222, 24'h088888, 24'h111111, 1'b1};
      vec[8]  = '{1'b0, 32, 24, 24'h333333, 24'h444444, 24'h333333, 24'h444444, 24'h199999, 24'h222222, 1'b0};
      vec[9]  = '{1'b0, 32, 24, 24'h0F0F0F, 24'hF0F0F0, 24'h0F0F0F, 24'hF0F0F0, 24'h078787, 24'h787878, 1'b1};
      for (int i = 10; i < 14; i++) begin
         logic [23:0] l, r;
         l = 24'($urandom);
         r = 24'($urandom);
         vec[i] = '{1'b0, 32, 24, l, r, l, r, l >> 1, r >> 1, 1'b1};
      end

      // Philips framing: exact in MODE 0, one-bit misaligned in MODE 1, incl. short slots
      do_reset(1'b0);
      run_segment(0, 4, 1'b0);
      drain();

      // left-justified framing: exact in MODE 1, one-bit misaligned in MODE 0
      do_reset(1'b0);
      run_segment(5, 6, 1'b1);
      drain();

      // back-pressure across two frames: first held, second dropped, overrun sticky
      do_reset(1'b0);
      out_ready = 1'b0;
      run_segment(7, 8, 1'b0);
      @(negedge clk);
      check("hold_valid0", 32'(out_valid0), 32'd1);
      check("hold_left0", {8'h0, out_left0}, 32'h111111);
      check("hold_right0", {8'h0, out_right0}, 32'h222222);
      check("hold_left1", {8'h0, out_left1}, 32'h088888);
      check("overrun0_set", 32'(overrun0), 32'd1);
      check("overrun1_set", 32'(overrun1), 32'd1);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      check("overrun0_cleared", 32'(overrun0), 32'd0);
      check("overrun1_cleared", 32'(overrun1), 32'd0);
      check("hold_valid0_after_clr", 32'(out_valid0), 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();
      check("overrun0_stays_clear", 32'(overrun0), 32'd0);

      // reset released in the middle of a right slot: partial frame never appears
      do_reset(1'b1);
      add_slot(1'b0, 32, 24, 24'hAAAAAA);
      add_slot(1'b1, 32, 24, 24'h555555);
      build_rows(9, 9);
      add_slot(1'b0, 4, 0, 24'h0);
      send_stream(1'b0, 48, 62);
      drain();

      // random payloads with sck at exactly clk/4 and random phase
      do_reset(1'b0);
      run_segment(10, 13, 1'b0);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
